// File: rtl/breakout_pkg.sv
// Shared screen defaults, source indices and the queued pixel entry type used by the
// breakout pixel path.
package breakout_pkg;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;
    localparam int unsigned NUM_SRC      = 3;

    localparam logic [1:0] SRC_PADDLE = 2'd0;
    localparam logic [1:0] SRC_BALL   = 2'd1;
    localparam logic [1:0] SRC_BRICK  = 2'd2;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    // Round-robin successor: paddle -> ball -> brick -> paddle.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_BRICK) ? SRC_PADDLE : s + 2'd1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel entries. A push while full is accepted only when the
// same cycle also pops, since the pop frees the slot first.
module pixel_fifo
    import breakout_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  pixel_t data_i,
    input  logic   pop_i,
    output pixel_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned Cw = Aw + 1;

    pixel_t          mem_q [Depth];
    logic [Aw-1:0]   wr_q, rd_q;
    logic [Cw-1:0]   cnt_q;
    logic            wr_en, rd_en;

    always_comb begin
        full_o  = (cnt_q == Cw'(Depth));
        empty_o = (cnt_q == '0);
        rd_en   = pop_i && !empty_o;
        wr_en   = push_i && (!full_o || rd_en);
        data_o  = mem_q[rd_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            if (wr_en && !rd_en) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/pixel_draw_arbiter.sv
// Buffers paddle/ball/brick pixel streams and merges them round-robin onto the VGA adapter.
// Optional full-screen clear sequencer is enabled with SCREEN_CLEAR_EN.
module pixel_draw_arbiter
    import breakout_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H   = DEF_SCREEN_H
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] paddle_x,
    input  logic [7:0] paddle_y,
    input  logic [2:0] paddle_colour,
    input  logic       paddle_plot,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [2:0] ball_colour,
    input  logic       ball_plot,
    input  logic [7:0] brick_x,
    input  logic [7:0] brick_y,
    input  logic [2:0] brick_colour,
    input  logic       brick_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
`ifdef SCREEN_CLEAR_EN
    input  logic       clear_req,
    output logic       clear_busy,
`endif
    output logic [2:0] overflow
);

    localparam logic [8:0] ScrW = 9'(SCREEN_W);
    localparam logic [8:0] ScrH = 9'(SCREEN_H);

    logic [7:0]         src_x    [0:NUM_SRC-1];
    logic [7:0]         src_y    [0:NUM_SRC-1];
    logic [2:0]         src_c    [0:NUM_SRC-1];
    logic [NUM_SRC-1:0] src_plot;
    logic [NUM_SRC-1:0] in_ok, pop, full, empty, drop;
    pixel_t             fifo_din [0:NUM_SRC-1];
    pixel_t             fifo_dout[0:NUM_SRC-1];

    logic [1:0] rr_q, rr_d, gnt_idx, cand;
    logic       gnt_valid, arb_en, grant;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d, overflow_q;
    logic       vga_plot_q, vga_plot_d;

    always_comb begin
        src_x[SRC_PADDLE] = paddle_x; src_y[SRC_PADDLE] = paddle_y;
        src_c[SRC_PADDLE] = paddle_colour;
        src_x[SRC_BALL]   = ball_x;   src_y[SRC_BALL]   = ball_y;
        src_c[SRC_BALL]   = ball_colour;
        src_x[SRC_BRICK]  = brick_x;  src_y[SRC_BRICK]  = brick_y;
        src_c[SRC_BRICK]  = brick_colour;
        src_plot = {brick_plot, ball_plot, paddle_plot};
    end

    // Off-screen pixels never reach a FIFO, so they cannot raise overflow.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ok[i]    = src_plot[i] && ({1'b0, src_x[i]} < ScrW) && ({1'b0, src_y[i]} < ScrH);
            fifo_din[i] = '{x: src_x[i], y: src_y[i][6:0], colour: src_c[i]};
            drop[i]     = in_ok[i] && full[i] && !pop[i];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        pixel_fifo #(
            .Depth(FIFO_DEPTH)
        ) u_fifo (
            .clk_i  (CLOCK_50),
            .rst_ni (resetn),
            .push_i (in_ok[g]),
            .data_i (fifo_din[g]),
            .pop_i  (pop[g]),
            .data_o (fifo_dout[g]),
            .full_o (full[g]),
            .empty_o(empty[g])
        );
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
            cand = next_src(cand);
        end
        grant = arb_en && gnt_valid;
        rr_d  = grant ? next_src(gnt_idx) : rr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = grant && (gnt_idx == 2'(i));
        end
    end

`ifdef SCREEN_CLEAR_EN
    typedef enum logic [0:0] {StArb, StClear} state_e;

    localparam logic [7:0] XLast = 8'(SCREEN_W - 1);
    localparam logic [6:0] YLast = 7'(SCREEN_H - 1);

    state_e     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;

    assign arb_en     = (state_q == StArb);
    assign clear_busy = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        unique case (state_q)
            StArb: begin
                if (clear_req) begin
                    state_d = StClear;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StClear: begin
                if (cx_q == XLast) begin
                    cx_d = '0;
                    if (cy_q == YLast) state_d = StArb;
                    else               cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StArb;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end
`else
    assign arb_en = 1'b1;
`endif

    always_comb begin
        vga_plot_d   = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if (grant) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = fifo_dout[gnt_idx].x;
            vga_y_d      = fifo_dout[gnt_idx].y;
            vga_colour_d = fifo_dout[gnt_idx].colour;
        end
`ifdef SCREEN_CLEAR_EN
        if (state_q == StClear) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = cx_q;
            vga_y_d      = cy_q;
            vga_colour_d = 3'b000;
        end
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rr_q         <= SRC_PADDLE;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            overflow_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            overflow_q   <= overflow_q | drop;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_draw_arbiter.sv
// Directed self-checking bench for pixel_draw_arbiter; the clear sequence is exercised
// only when SCREEN_CLEAR_EN is defined.
module tb_pixel_draw_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] paddle_x, paddle_y, ball_x, ball_y, brick_x, brick_y;
    logic [2:0] paddle_colour, ball_colour, brick_colour;
    logic       paddle_plot, ball_plot, brick_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour, overflow;
    logic       vga_plot;
    logic       clear_req, clear_busy;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    pixel_draw_arbiter dut (
`ifdef SCREEN_CLEAR_EN
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
`endif
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .paddle_colour(paddle_colour),
        .paddle_plot  (paddle_plot),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_colour  (ball_colour),
        .ball_plot    (ball_plot),
        .brick_x      (brick_x),
        .brick_y      (brick_y),
        .brick_colour (brick_colour),
        .brick_plot   (brick_plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .overflow     (overflow)
    );

    typedef struct {
        bit         rst;
        logic [7:0] px, py; logic [2:0] pc; logic pp;
        logic [7:0] bx, by; logic [2:0] bc; logic bp;
        logic [7:0] rx, ry; logic [2:0] rc; logic rp;
        logic       eplot;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic [2:0] eovf;
    } vec_t;

    vec_t tbl[13];
    logic [7:0] alt_exp[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        paddle_plot = 1'b0; ball_plot = 1'b0; brick_plot = 1'b0; clear_req = 1'b0;
    endtask

    // Called at a falling edge; reset is released well before the next rising edge.
    task automatic do_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    int busy_cnt, bad_col;
    bit first_seen;
    logic [7:0] first_x;
    logic [6:0] first_y;

    initial begin
        // rst, paddle, ball, brick, expected plot/x/y/colour/overflow
        tbl[0]  = '{1, 40,110,7,1,  0,0,0,0,     0,0,0,0,    0, 0,0,0, 0};
        tbl[1]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    1, 40,110,7, 0};
        tbl[2]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    0, 40,110,7, 0};
        tbl[3]  = '{1, 10,110,1,1,  50,60,2,1,   80,5,3,1,   0, 0,0,0, 0};
        tbl[4]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    1, 10,110,1, 0};
        tbl[5]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    1, 50,60,2, 0};
        tbl[6]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    1, 80,5,3, 0};
        tbl[7]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    0, 80,5,3, 0};
        tbl[8]  = '{0, 0,0,0,0,     170,60,5,1,  20,125,6,1, 0, 80,5,3, 0};
        tbl[9]  = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    0, 80,5,3, 0};
        tbl[10] = '{0, 159,119,4,1, 0,0,0,0,     0,0,0,0,    0, 80,5,3, 0};
        tbl[11] = '{0, 0,0,0,0,     160,0,4,1,   0,120,2,1,  1, 159,119,4, 0};
        tbl[12] = '{0, 0,0,0,0,     0,0,0,0,     0,0,0,0,    0, 159,119,4, 0};
        alt_exp = '{0, 100, 1, 101, 2, 102, 3, 103, 4, 104, 5, 105, 6, 106, 7, 108, 9, 110, 11};

        resetn = 1'b0;
        idle();
        paddle_x = '0; paddle_y = '0; paddle_colour = '0;
        ball_x = '0; ball_y = '0; ball_colour = '0;
        brick_x = '0; brick_y = '0; brick_colour = '0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset plot", vga_plot, 0);
        check("reset xyc", {vga_x, vga_y, vga_colour}, 0);
        check("reset overflow", overflow, 0);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            paddle_x = tbl[i].px; paddle_y = tbl[i].py;
            paddle_colour = tbl[i].pc; paddle_plot = tbl[i].pp;
            ball_x = tbl[i].bx; ball_y = tbl[i].by;
            ball_colour = tbl[i].bc; ball_plot = tbl[i].bp;
            brick_x = tbl[i].rx; brick_y = tbl[i].ry;
            brick_colour = tbl[i].rc; brick_plot = tbl[i].rp;
            cycle();
            check($sformatf("v%0d plot", i), vga_plot, tbl[i].eplot);
            check($sformatf("v%0d x", i), vga_x, tbl[i].ex);
            check($sformatf("v%0d y", i), vga_y, tbl[i].ey);
            check($sformatf("v%0d colour", i), vga_colour, tbl[i].ec);
            check($sformatf("v%0d overflow", i), overflow, tbl[i].eovf);
        end
        idle();

        // Paddle and ball both stream for 12 cycles: alternating output, late drops.
        do_reset();
        for (int e = 1; e <= 21; e++) begin
            idle();
            if (e <= 12) begin
                paddle_plot = 1'b1; paddle_x = 8'(e - 1); paddle_y = 8'd1; paddle_colour = 3'd1;
                ball_plot = 1'b1; ball_x = 8'(99 + e); ball_y = 8'd2; ball_colour = 3'd2;
            end
            cycle();
            if (e >= 2 && e <= 20) begin
                check($sformatf("alt%0d plot", e), vga_plot, 1);
                check($sformatf("alt%0d x", e), vga_x, alt_exp[e-2]);
                check($sformatf("alt%0d y", e), vga_y, (alt_exp[e-2] >= 8'd100) ? 2 : 1);
            end
        end
        check("alt drained plot", vga_plot, 0);
        check("alt overflow", overflow, 3'b011);

        // Asynchronous reset with pixels still queued.
        do_reset();
        paddle_plot = 1'b1; paddle_x = 8'd1; paddle_y = 8'd1; paddle_colour = 3'd1;
        ball_plot = 1'b1; ball_x = 8'd2; ball_y = 8'd2; ball_colour = 3'd2;
        brick_plot = 1'b1; brick_x = 8'd3; brick_y = 8'd3; brick_colour = 3'd3;
        cycle();
        idle();
        cycle();
        check("pre-reset plot", vga_plot, 1);
        check("pre-reset x", vga_x, 1);
        #2 resetn = 1'b0;
        #1;
        check("async reset plot", vga_plot, 0);
        check("async reset x", vga_x, 0);
        #1 resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLOCK_50);
            check($sformatf("no stale %0d", c), vga_plot, 0);
        end

`ifdef SCREEN_CLEAR_EN
        do_reset();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        busy_cnt = 0; bad_col = 0; first_seen = 0; first_x = '1; first_y = '1;
        while (clear_busy && busy_cnt < 20000) begin
            busy_cnt++;
            if (vga_plot) begin
                if (!first_seen) begin
                    first_seen = 1; first_x = vga_x; first_y = vga_y;
                end
                if (vga_colour != 3'd0) bad_col++;
            end
            paddle_plot = (busy_cnt == 5);
            paddle_x = 8'd33; paddle_y = 8'd44; paddle_colour = 3'd5;
            cycle();
        end
        paddle_plot = 1'b0;
        check("clear busy cycles", busy_cnt, 19200);
        check("clear first x", first_x, 0);
        check("clear first y", first_y, 0);
        check("clear colour", bad_col, 0);
        check("clear last plot", vga_plot, 1);
        check("clear last xyc", {vga_x, vga_y, vga_colour}, {8'd159, 7'd119, 3'd0});
        cycle();
        check("post-clear plot", vga_plot, 1);
        check("post-clear xyc", {vga_x, vga_y, vga_colour}, {8'd33, 7'd44, 3'd5});
        check("post-clear overflow", overflow, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
